multi_timer: RTL

- Parametrised multi-channel successor to the single-channel bus timer.
- Bus-mapped peripheral on the CPU data bridge. Provides NUM_CH independent down-counters, each with one-shot or auto-reload mode.
- Each channel has a sticky pending flag with write-1-to-clear and an interrupt mask.
- Drives one combined IRQ line to CP0 plus a per-channel vector.

---
 rtl/multi_timer_pkg.sv | 24 ++
 rtl/timer_channel.sv | 175 +++++++++++++++++
 rtl/multi_timer.sv | 75 +++++++
 3 files changed

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared encodings for the multi-channel bus timer.
// Channel FSM states, per-channel register offsets and CTRL bit positions.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    // Word offsets inside a channel's 4-word window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IM     = 3;
    localparam int unsigned CTRL_PS_LSB = 8;
    localparam int unsigned CTRL_PS_MSB = 15;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counter with CTRL/PRESET/COUNT, sticky pending flag and
// interrupt mask. A bus write to this channel freezes its FSM and count for that cycle.
// Optional prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] din,
    input  logic [1:0]  offset,
    input  logic        w1c,
    output logic [31:0] rdata,
    output logic        pending,
    output logic        irq
);

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic               reload_q, reload_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pending_q, pending_d;
    logic               pend_set;
    logic               wr;
    logic               tick;

    assign wr = sel && we;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [7:0] ps_q, ps_d;
    logic [7:0] ps_cnt_q, ps_cnt_d;

    assign tick = (ps_cnt_q == ps_q);
`else
    assign tick = 1'b1;
`endif

    // Only part of the bus word is stored; the rest is dropped on write
    logic unused_din;
    assign unused_din = ^din;

    // State and register update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
`ifdef MULTI_TIMER_PRESCALE_EN
            ps_q      <= '0;
            ps_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            reload_q  <= reload_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
`ifdef MULTI_TIMER_PRESCALE_EN
            ps_q      <= ps_d;
            ps_cnt_q  <= ps_cnt_d;
`endif
        end
    end

    // Next state: bus writes take priority over the counting FSM
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        reload_d = reload_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_set = 1'b0;
`ifdef MULTI_TIMER_PRESCALE_EN
        ps_d     = ps_q;
        ps_cnt_d = ps_cnt_q;
`endif
        if (wr) begin
            case (offset)
                OFF_CTRL: begin
                    en_d     = din[CTRL_EN];
                    reload_d = din[CTRL_RELOAD];
                    im_d     = din[CTRL_IM];
`ifdef MULTI_TIMER_PRESCALE_EN
                    ps_d     = din[CTRL_PS_MSB:CTRL_PS_LSB];
`endif
                end
                OFF_PRESET: preset_d = din[CNT_W-1:0];
                OFF_COUNT:  count_d  = din[CNT_W-1:0];
                default: ;
            endcase
`ifdef MULTI_TIMER_PRESCALE_EN
            ps_cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_q) state_d = StLoad;
                end
                StLoad: begin
                    count_d = preset_q;
                    state_d = StCnt;
`ifdef MULTI_TIMER_PRESCALE_EN
                    ps_cnt_d = '0;
`endif
                end
                StCnt: begin
                    if (!en_q) begin
                        state_d = StIdle;
                    end else begin
`ifdef MULTI_TIMER_PRESCALE_EN
                        ps_cnt_d = tick ? 8'd0 : ps_cnt_q + 8'd1;
`endif
                        if (tick) begin
                            // PRESET of 0 expires like 1: no wrap below zero
                            if (count_q > CNT_W'(1)) begin
                                count_d = count_q - CNT_W'(1);
                            end else begin
                                count_d  = '0;
                                pend_set = 1'b1;
                                state_d  = StInt;
                            end
                        end
                    end
                end
                StInt: begin
                    if (!reload_q) begin
                        en_d    = 1'b0;
                        state_d = StIdle;
                    end else if (en_q) begin
                        count_d = preset_q;
                        state_d = StCnt;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // A set in the same cycle as a clear wins
        pending_d = (pending_q && !w1c) || pend_set;
    end

    // Register read-back and masked interrupt
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL: begin
                rdata[CTRL_EN]     = en_q;
                rdata[CTRL_RELOAD] = reload_q;
                rdata[CTRL_IM]     = im_q;
`ifdef MULTI_TIMER_PRESCALE_EN
                rdata[CTRL_PS_MSB:CTRL_PS_LSB] = ps_q;
`endif
            end
            OFF_PRESET: rdata = 32'(preset_q);
            OFF_COUNT:  rdata = 32'(count_q);
            default:    rdata = '0;
        endcase
        pending = pending_q;
        irq     = pending_q && im_q;
    end

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH bus-mapped down-counters with a shared W1C STATUS register
// and a combined IRQ. Optional per-channel prescaler: define MULTI_TIMER_PRESCALE_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       addr,
    input  logic              we,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    // Eight channels push STATUS to word 32, which needs one extra address bit
    localparam int unsigned AW = (NUM_CH > 7) ? 6 : 5;
    localparam int unsigned IW = AW - 2;
    localparam logic [AW-1:0] STATUS_WORD = AW'(4 * NUM_CH);
    localparam logic [IW-1:0] CH_LIM      = IW'(NUM_CH);

    logic [AW-1:0]     word;
    logic [IW-1:0]     ch_idx;
    logic [1:0]        offset;
    logic              ch_hit;
    logic              status_hit;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] pend;
    logic [31:0]       ch_rdata [NUM_CH];

    logic unused_addr;
    assign unused_addr = ^addr[29:AW];

    assign word       = addr[AW-1:0];
    assign ch_idx     = word[AW-1:2];
    assign offset     = word[1:0];
    assign ch_hit     = (ch_idx < CH_LIM);
    assign status_hit = (word == STATUS_WORD);
    assign w1c        = (we && status_hit) ? din[NUM_CH-1:0] : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign sel[c] = ch_hit && (ch_idx == IW'(c));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .sel    (sel[c]),
            .we     (we),
            .din    (din),
            .offset (offset),
            .w1c    (w1c[c]),
            .rdata  (ch_rdata[c]),
            .pending(pend[c]),
            .irq    (irq_vec[c])
        );
    end

    // Read mux: selected channel, STATUS, or zero
    always_comb begin
        dout = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel[c]) dout = ch_rdata[c];
        end
        if (status_hit) dout = 32'(pend);
    end

    assign irq = |irq_vec;

endmodule
